// File: rtl/ex_div_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ex_div_if                                                   |
// | Desc   : EX-stage divider handshake bundle (pipeline <-> divider).   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface ex_div_if #(
   parameter int XLEN = 32
);
   logic            e_start;
   logic [2:0]      e_funct3;
   logic [XLEN-1:0] e_src_a;
   logic [XLEN-1:0] e_src_b;
   logic            e_flush;
   logic [XLEN-1:0] e_div_result;
   logic            e_div_busy;
   logic            e_div_done;

   modport master (
      output e_start, e_funct3, e_src_a, e_src_b, e_flush,
      input  e_div_result, e_div_busy, e_div_done
   );

   modport slave (
      input  e_start, e_funct3, e_src_a, e_src_b, e_flush,
      output e_div_result, e_div_busy, e_div_done
   );
endinterface
`default_nettype wire

// File: rtl/ex_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : ex_div_unit                                                 |
// | Desc   : Iterative radix-2 restoring RV32M divider (DIV/DIVU/REM/REMU)|
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module ex_div_unit #(
   parameter int XLEN = 32
) (
   input  wire       clk,
   input  wire       reset,
   ex_div_if.slave   div
);
   localparam int CW = $clog2(XLEN);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_calc = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [CW-1:0]   c_cnt_init = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] c_one      = {{(XLEN-1){1'b0}}, 1'b1};
   localparam logic [XLEN-1:0] c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        r_state;
   logic [1:0]        w_state_next;
   logic [CW-1:0]     r_cnt;
   logic [2*XLEN:0]   r_acc;
   logic [XLEN-1:0]   r_divisor;
   logic              r_is_rem;
   logic              r_neg_q;
   logic              r_neg_r;
   logic [XLEN-1:0]   r_result;
   logic              w_busy;
   logic              w_done;

   // Operand decode, only meaningful while IDLE
   logic              w_signed;
   logic              w_is_rem;
   logic              w_accept;
   logic              w_div0;
   logic              w_ovf;
   logic [XLEN-1:0]   w_abs_a;
   logic [XLEN-1:0]   w_abs_b;

   assign w_signed = ~div.e_funct3[0];
   assign w_is_rem = div.e_funct3[1];
   assign w_accept = (r_state == c_idle) & div.e_start & ~div.e_flush;
   assign w_div0   = (div.e_src_b == '0);
   assign w_ovf    = w_signed & (div.e_src_a == c_int_min) & (div.e_src_b == '1);
   assign w_abs_a  = (w_signed & div.e_src_a[XLEN-1]) ? -div.e_src_a : div.e_src_a;
   assign w_abs_b  = (w_signed & div.e_src_b[XLEN-1]) ? -div.e_src_b : div.e_src_b;

   // One restoring step on {rem, quo}; the extra top bit keeps the shifted remainder exact
   logic [2*XLEN:0]   w_sh;
   logic [XLEN+1:0]   w_trial;
   logic              w_ge;
   logic [2*XLEN:0]   w_acc_next;
   logic [XLEN-1:0]   w_quo_fin;
   logic [XLEN-1:0]   w_rem_fin;
   logic [XLEN-1:0]   w_result_fix;

   assign w_sh       = r_acc << 1;
   assign w_trial    = {1'b0, w_sh[2*XLEN:XLEN]} - {2'b00, r_divisor};
   assign w_ge       = ~w_trial[XLEN+1];
   assign w_acc_next = w_ge ? {w_trial[XLEN:0], w_sh[XLEN-1:0] | c_one} : w_sh;
   assign w_quo_fin  = r_neg_q ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
   assign w_rem_fin  = r_neg_r ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
   assign w_result_fix = r_is_rem ? w_rem_fin : w_quo_fin;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_idle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle: begin
            if (w_accept) w_state_next = (w_div0 | w_ovf) ? c_done : c_calc;
         end
         c_calc: begin
            if (div.e_flush)          w_state_next = c_idle;
            else if (r_cnt == '0)     w_state_next = c_done;
         end
         c_done:  w_state_next = c_idle;
         default: w_state_next = c_idle;
      endcase
   end

   always_comb begin
      w_busy = 1'b0;
      w_done = 1'b0;
      if (!reset) begin
         w_busy = w_accept | (r_state == c_calc);
         w_done = (r_state == c_done) & ~div.e_flush;
      end
   end

   // Result is loaded on the edge entering DONE so it is valid during the done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_acc     <= '0;
         r_divisor <= '0;
         r_is_rem  <= 1'b0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_result  <= '0;
      end else begin
         case (r_state)
            c_idle: begin
               if (w_accept) begin
                  r_is_rem  <= w_is_rem;
                  r_neg_q   <= w_signed & (div.e_src_a[XLEN-1] ^ div.e_src_b[XLEN-1]);
                  r_neg_r   <= w_signed & div.e_src_a[XLEN-1];
                  r_divisor <= w_abs_b;
                  r_acc     <= {{(XLEN+1){1'b0}}, w_abs_a};
                  r_cnt     <= c_cnt_init;
                  if (w_div0)     r_result <= w_is_rem ? div.e_src_a : '1;
                  else if (w_ovf) r_result <= w_is_rem ? '0 : c_int_min;
               end
            end
            c_calc: begin
               if (!div.e_flush) begin
                  r_acc <= w_acc_next;
                  r_cnt <= r_cnt - 1'b1;
                  if (r_cnt == '0) r_result <= w_result_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign div.e_div_result = r_result;
   assign div.e_div_busy   = w_busy;
   assign div.e_div_done   = w_done;
endmodule
`default_nettype wire
